ether_tx_fifo_reader: RTL and testbench
=======================================

Name: ether_tx_fifo_reader

Overview:
- Read-side master for usb2ether_fifo. Drains one buffered packet at a time from the FIFO and presents it byte by byte on the Ethernet-side transmit byte stream.
- Per-packet length descriptor comes from the bridge controller.
- On a transmit abort (collision or late error) the block pulses read_error to rewind the FIFO read pointer to the packet start, then retransmits the packet.
- After MAX_RETRY failed attempts it discards the packet.

Parameters:
LEN_W, 11, width of packet length and byte counter (max 2047 bytes)
MAX_RETRY, 4, transmit attempts before the packet is discarded (1..15)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
pkt_valid  in  1  length descriptor valid
pkt_len  in  LEN_W  packet length in bytes
pkt_ready  out  1  descriptor accepted (one-cycle pulse)
fifo_empty  in  1  from FIFO
read_data  in  8  FIFO data, valid the cycle after read_enable
read_enable  out  1  FIFO pop, one-cycle pulse per byte
read_start  out  1  marks first pop of a packet attempt (FIFO latches rewind point)
read_error  out  1  rewinds FIFO read pointer to last read_start
tx_data  out  8  transmit byte
tx_valid  out  1  tx_data valid
tx_sop  out  1  first byte of attempt, qualified by tx_valid
tx_eop  out  1  last byte, qualified by tx_valid
tx_ready  in  1  sink accepts byte when tx_valid & tx_ready
tx_abort  in  1  sink aborts current attempt
tx_done  out  1  one-cycle pulse: packet sent
tx_fail  out  1  one-cycle pulse: packet discarded after MAX_RETRY attempts

Behaviour:
- Reset: clk and n_rst only; reset is asynchronous and active-low. All outputs 0, FSM in IDLE, byte and retry counters 0, len register 0.
- IDLE:
  - If pkt_valid, pulse pkt_ready and latch pkt_len; retry=0, cnt=0.
  - If len==0, pulse tx_done next cycle, do no FIFO reads, return to IDLE. Otherwise go to FETCH.
- FETCH:
  - If !fifo_empty: read_enable=1 for one cycle; read_start=1 with it when cnt==0. Go to WAIT.
  - If fifo_empty: stall in FETCH with no pop (underrun stall, no timeout).
- WAIT: capture read_data into tx_data and go to SEND. Pop at cycle N gives tx_valid at cycle N+2.
- SEND:
  - tx_valid=1; tx_sop=(cnt==0); tx_eop=(cnt==len-1). tx_data, sop and eop are held stable until accepted.
  - On tx_ready: cnt++. If this was the last byte, go to DONE, else go to FETCH.
  - Minimum 3 cycles per byte; no pipelining of pops.
- DONE: tx_done pulse one cycle, then IDLE.
- tx_abort:
  - Sampled in FETCH, WAIT and SEND; ignored in IDLE, DONE, REWIND and DISCARD.
  - Next cycle: tx_valid=0, read_error pulses one cycle, any pending pop is cancelled, retry++.
  - If retry < MAX_RETRY: go to REWIND (one idle cycle), then cnt=0 and FETCH, re-issuing read_start.
  - Else: pulse tx_fail and go to DISCARD with cnt=0.
- tx_abort simultaneous with tx_ready on the last byte: abort wins; the byte is not counted and no tx_done is issued.
- DISCARD: pop len bytes (read_start on first) with the same FETCH/WAIT pacing and tx_valid held 0, then IDLE without tx_done.
- read_enable never asserts while fifo_empty=1.
- read_start, read_error and read_enable are never asserted together.
- cnt compares at LEN_W bits; no wrap is possible since cnt<=len.
- Reset mid-packet: all outputs drop asynchronously; FIFO pointer recovery is the FIFO's responsibility.

Test Plan:
- Reset with n_rst low for 2 cycles -> all outputs 0. Write bytes 0x00..0x09 into the FIFO, give pkt_len=10, hold tx_ready=1 -> tx_data 0x00..0x09 in order; sop only on 0x00, eop only on 0x09; one tx_done pulse; fifo_empty=1 afterwards.
- Backpressure: len=4, tx_ready toggles every other cycle -> each byte held stable until accepted; exactly 4 pops.
- Abort on byte 3 of 6 (data 0xA0..0xA5) -> read_error pulse; retransmit begins with read_start and sop on 0xA0; all 6 bytes sent; tx_done; retry count 1.
- Abort on every attempt, MAX_RETRY=4, len=5 -> 4 read_error pulses, then tx_fail. 5 discard pops with tx_valid=0 and no tx_done. A following packet 0x55,0x66 transmits correctly.
- Underrun: len=3 with only 1 byte in the FIFO -> block stalls in FETCH with no pops while empty; resumes when bytes 2 and 3 are written; eop on byte 3.
- len=0 descriptor -> pkt_ready and tx_done pulses, zero read_enable.

Source files
------------

// File: rtl/ether_tx_fifo_reader.sv
// Purpose: drains one buffered packet per length descriptor from the tx FIFO onto the byte stream, with rewind/retry on abort.
// Latency: a pop in cycle N presents the byte with tx_valid in cycle N+2; at least 3 cycles per byte, one pop in flight.
// Backpressure: a byte is held on tx_data/tx_sop/tx_eop until tx_ready; an empty FIFO stalls the fetch indefinitely.
module ether_tx_fifo_reader #(
   parameter int LEN_W     = 11,
   parameter int MAX_RETRY = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             pkt_valid,
   input  logic [LEN_W-1:0] pkt_len,
   output logic             pkt_ready,
   input  logic             fifo_empty,
   input  logic [7:0]       read_data,
   output logic             read_enable,
   output logic             read_start,
   output logic             read_error,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   output logic             tx_sop,
   output logic             tx_eop,
   input  logic             tx_ready,
   input  logic             tx_abort,
   output logic             tx_done,
   output logic             tx_fail
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_WAIT, S_SEND, S_DONE,
      S_ABORT, S_REWIND, S_FAIL, S_DFETCH, S_DWAIT
   } state_t;

   localparam logic [3:0] MAX_RETRY_L = 4'(MAX_RETRY);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d;
   logic [7:0]       data_q, data_d;
   logic             last_byte;
   logic [3:0]       retry_inc;

   assign last_byte = (cnt_q == len_q - LEN_W'(1));
   assign retry_inc = retry_q + 4'd1;
   assign tx_data   = data_q;

   // State and datapath registers; everything clears on reset so outputs drop at once.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         retry_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         data_q  <= data_d;
      end
   end

   // Next-state and output decode; an abort seen in FETCH/WAIT/SEND cancels any pop and wins over tx_ready.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      retry_d     = retry_q;
      data_d      = data_q;
      pkt_ready   = 1'b0;
      read_enable = 1'b0;
      read_start  = 1'b0;
      read_error  = 1'b0;
      tx_valid    = 1'b0;
      tx_sop      = 1'b0;
      tx_eop      = 1'b0;
      tx_done     = 1'b0;
      tx_fail     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pkt_valid) begin
               pkt_ready = 1'b1;
               len_d     = pkt_len;
               cnt_d     = '0;
               retry_d   = '0;
               state_d   = (pkt_len == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            if (tx_abort) begin
               state_d = S_ABORT;
            end else if (!fifo_empty) begin
               read_enable = 1'b1;
               read_start  = (cnt_q == '0);
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            data_d  = read_data;
            state_d = tx_abort ? S_ABORT : S_SEND;
         end
         S_SEND: begin
            tx_valid = 1'b1;
            tx_sop   = (cnt_q == '0);
            tx_eop   = last_byte;
            if (tx_abort) begin
               state_d = S_ABORT;
            end else if (tx_ready) begin
               cnt_d   = cnt_q + LEN_W'(1);
               state_d = last_byte ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            tx_done = 1'b1;
            state_d = S_IDLE;
         end
         S_ABORT: begin
            read_error = 1'b1;
            retry_d    = retry_inc;
            cnt_d      = '0;
            state_d    = (retry_inc < MAX_RETRY_L) ? S_REWIND : S_FAIL;
         end
         S_REWIND: begin
            cnt_d   = '0;
            state_d = S_FETCH;
         end
         S_FAIL: begin
            tx_fail = 1'b1;
            cnt_d   = '0;
            state_d = S_DFETCH;
         end
         S_DFETCH: begin
            if (!fifo_empty) begin
               read_enable = 1'b1;
               read_start  = (cnt_q == '0);
               cnt_d       = cnt_q + LEN_W'(1);
               state_d     = S_DWAIT;
            end
         end
         S_DWAIT: begin
            state_d = (cnt_q == len_q) ? S_IDLE : S_DFETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ether_tx_fifo_reader.sv
// Purpose: self-checking bench for ether_tx_fifo_reader with a rewindable FIFO model and per-packet outcome model.
// Latency: outputs sampled 1 time unit after the falling edge, inputs driven on the falling edge.
// Backpressure: sink ready is always-on, toggling or random; aborts are injected on planned byte indices.
module tb_ether_tx_fifo_reader;

   localparam int LW = 11;
   localparam int MR = 4;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          pkt_valid;
   logic [LW-1:0] pkt_len;
   logic          pkt_ready;
   logic          fifo_empty;
   logic [7:0]    read_data;
   logic          read_enable, read_start, read_error;
   logic [7:0]    tx_data;
   logic          tx_valid, tx_sop, tx_eop;
   logic          tx_ready, tx_abort;
   logic          tx_done, tx_fail;

   ether_tx_fifo_reader #(.LEN_W(LW), .MAX_RETRY(MR)) dut (
      .clk(clk), .n_rst(n_rst),
      .pkt_valid(pkt_valid), .pkt_len(pkt_len), .pkt_ready(pkt_ready),
      .fifo_empty(fifo_empty), .read_data(read_data),
      .read_enable(read_enable), .read_start(read_start), .read_error(read_error),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
      .tx_ready(tx_ready), .tx_abort(tx_abort),
      .tx_done(tx_done), .tx_fail(tx_fail)
   );

   always #5 clk = ~clk;

   // Rewindable FIFO: read_start latches the packet start, read_error returns the read pointer to it.
   logic [7:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int st_ptr = 0;
   assign fifo_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      if (read_error) begin
         rd_ptr <= st_ptr;
      end else if (read_enable) begin
         read_data <= mem[rd_ptr % 256];
         rd_ptr    <= rd_ptr + 1;
         if (read_start) st_ptr <= rd_ptr;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      int len; int base; int step; int nab; int abidx; int prefill; int rmode;
      int exp_done; int exp_fail; int exp_pops; int exp_rerr;
   } vec_t;

   // Current packet plan and observed results
   int p_len, p_prefill, p_rmode, p_nab;
   int p_ab [MR];
   logic [7:0] p_dat [0:255];
   int o_done, o_fail, o_pops, o_rerr, o_rdy, o_sent;

   task automatic run_pkt();
      int a, idx, quiet;
      bit finished, need_start, hold;
      logic [7:0] h_d;
      logic h_s, h_e;
      a = 0; idx = 0; quiet = 0; finished = 0; need_start = 1; hold = 0;
      h_d = '0; h_s = 0; h_e = 0;
      o_done = 0; o_fail = 0; o_pops = 0; o_rerr = 0; o_rdy = 0;
      for (int i = 0; i < p_prefill; i++) begin
         mem[wr_ptr % 256] = p_dat[i];
         wr_ptr++;
      end
      for (int cyc = 0; cyc < 4000 && !(finished && quiet >= 4); cyc++) begin
         @(negedge clk);
         if (cyc == 30) begin
            for (int i = p_prefill; i < p_len; i++) begin
               mem[wr_ptr % 256] = p_dat[i];
               wr_ptr++;
            end
         end
         pkt_valid = (o_rdy == 0);
         pkt_len   = LW'(p_len);
         case (p_rmode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 2 == 1);
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
         tx_abort = tx_valid && (a < p_nab) && (idx == p_ab[a]);
         #1;
         chk("pop_while_empty", int'(read_enable & fifo_empty), 0);
         chk("error_with_pop", int'(read_error & (read_enable | read_start)), 0);
         chk("start_without_pop", int'(read_start & ~read_enable), 0);
         if (o_fail > 0) chk("valid_in_discard", int'(tx_valid), 0);
         if (pkt_ready) o_rdy++;
         if (read_enable) begin
            chk("read_start", int'(read_start), int'(need_start));
            need_start = 0;
            o_pops++;
         end
         if (read_error) begin
            o_rerr++;
            need_start = 1;
         end
         if (hold) begin
            chk("hold_valid", int'(tx_valid), 1);
            chk("hold_data", int'(tx_data), int'(h_d));
            chk("hold_sop", int'(tx_sop), int'(h_s));
            chk("hold_eop", int'(tx_eop), int'(h_e));
         end
         hold = 0;
         if (tx_valid) begin
            if (tx_abort) begin
               a++;
               idx = 0;
            end else begin
               chk("tx_data", int'(tx_data), int'(p_dat[idx % 256]));
               chk("tx_sop", int'(tx_sop), int'(idx == 0));
               chk("tx_eop", int'(tx_eop), int'(idx == p_len - 1));
               if (tx_ready) begin
                  idx++;
               end else begin
                  hold = 1; h_d = tx_data; h_s = tx_sop; h_e = tx_eop;
               end
            end
         end
         if (tx_done) o_done++;
         if (tx_fail) o_fail++;
         finished = (o_done + o_fail) > 0;
         if (finished && !read_enable) quiet++;
         else quiet = 0;
      end
      chk("pkt_completed", int'(finished && quiet >= 4), 1);
      chk("fifo_drained", int'(fifo_empty), 1);
      @(negedge clk);
      pkt_valid = 1'b0;
      tx_abort  = 1'b0;
      o_sent    = idx;
   endtask

   task automatic compare(input string nm, input int e_done, input int e_fail,
                          input int e_pops, input int e_rerr);
      chk({nm, "_done"}, o_done, e_done);
      chk({nm, "_fail"}, o_fail, e_fail);
      chk({nm, "_pops"}, o_pops, e_pops);
      chk({nm, "_read_error"}, o_rerr, e_rerr);
      chk({nm, "_pkt_ready"}, o_rdy, 1);
      chk({nm, "_bytes_sent"}, o_sent, (e_done != 0) ? p_len : 0);
   endtask

   vec_t vt [7];

   initial begin
      int sum;
      // len base step nab abidx prefill rmode | done fail pops rerr
      vt[0] = '{10, 'h00, 1,    0, 0, 10, 0,  1, 0, 10, 0};
      vt[1] = '{4,  'h30, 1,    0, 0, 4,  1,  1, 0, 4,  0};
      vt[2] = '{6,  'hA0, 1,    1, 2, 6,  0,  1, 0, 9,  1};
      vt[3] = '{5,  'hC0, 1,    4, 0, 5,  0,  0, 1, 9,  4};
      vt[4] = '{2,  'h55, 'h11, 0, 0, 2,  0,  1, 0, 2,  0};
      vt[5] = '{3,  'h70, 1,    0, 0, 1,  0,  1, 0, 3,  0};
      vt[6] = '{0,  'h00, 1,    0, 0, 0,  0,  1, 0, 0,  0};

      n_rst = 1'b0; pkt_valid = 1'b0; pkt_len = '0; tx_ready = 1'b0; tx_abort = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pkt_ready", int'(pkt_ready), 0);
      chk("rst_read_enable", int'(read_enable), 0);
      chk("rst_read_start", int'(read_start), 0);
      chk("rst_read_error", int'(read_error), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      chk("rst_tx_valid", int'(tx_valid), 0);
      chk("rst_tx_sop", int'(tx_sop), 0);
      chk("rst_tx_eop", int'(tx_eop), 0);
      chk("rst_tx_done", int'(tx_done), 0);
      chk("rst_tx_fail", int'(tx_fail), 0);
      n_rst = 1'b1;
      @(negedge clk);

      // Directed vectors
      for (int v = 0; v < 7; v++) begin
         p_len = vt[v].len; p_prefill = vt[v].prefill; p_rmode = vt[v].rmode;
         p_nab = vt[v].nab;
         for (int i = 0; i < MR; i++) p_ab[i] = vt[v].abidx;
         for (int i = 0; i < 256; i++) p_dat[i] = 8'(vt[v].base + i * vt[v].step);
         run_pkt();
         compare($sformatf("vec%0d", v), vt[v].exp_done, vt[v].exp_fail,
                 vt[v].exp_pops, vt[v].exp_rerr);
      end

      // Random packets: outcome follows from the abort plan alone
      for (int n = 0; n < 40; n++) begin
         int r;
         p_len = $urandom_range(0, 20);
         r = $urandom_range(0, 9);
         if (p_len == 0 || r < 5) p_nab = 0;
         else if (r < 8)          p_nab = $urandom_range(1, MR - 1);
         else                     p_nab = MR;
         sum = 0;
         for (int i = 0; i < MR; i++) begin
            p_ab[i] = (p_len > 0) ? $urandom_range(0, p_len - 1) : 0;
            if (i < p_nab) sum += p_ab[i] + 1;
         end
         p_prefill = ($urandom_range(0, 4) == 0) ? $urandom_range(0, p_len) : p_len;
         p_rmode = 2;
         for (int i = 0; i < 256; i++) p_dat[i] = 8'($urandom);
         run_pkt();
         compare($sformatf("rnd%0d", n), (p_nab < MR) ? 1 : 0, (p_nab >= MR) ? 1 : 0,
                 p_len + sum, p_nab);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
